// File: rtl/count_pkg.sv
// Shared types for the count_unit slice: wrap-mode encoding.
package count_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    MOD     = 2'd1,
    SAT     = 2'd2,
    ONESHOT = 2'd3
  } mode_e;

endpackage

// File: rtl/count_unit_if.sv
// Control/status bundle of count_unit; master drives controls, slave is the counter.
interface count_unit_if
  import count_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);

  logic               en;
  logic               dir;
  mode_e              mode;
  logic [WIDTH-1:0]   modulus;
  logic [PRESC_W-1:0] presc_div;
  logic               ld;
  logic [WIDTH-1:0]   ld_val;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               zero;
  logic               running;

  modport master (
    output en, dir, mode, modulus, presc_div, ld, ld_val,
    input  count, tc, zero, running
  );

  modport slave (
    input  en, dir, mode, modulus, presc_div, ld, ld_val,
    output count, tc, zero, running
  );

endinterface

// File: rtl/count_prescaler.sv
// Prescaler: emits one tick per div+1 enabled cycles; clr restarts the phase.
module count_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;

  // >= rather than == so a mid-run shrink of div ticks at once instead of overflowing
  assign tick = en & (pcnt_q >= div);

  // Next phase: clear on load or tick, advance on enable, else hold
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = {PRESC_W{1'b0}};
    end else if (tick) begin
      pcnt_d = {PRESC_W{1'b0}};
    end else if (en) begin
      pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Phase register
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= {PRESC_W{1'b0}};
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/count_unit.sv
// Up/down counter with load, prescaler and WRAP/MOD/SAT/ONESHOT terminal handling.
module count_unit
  import count_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  count_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q, running_d;
  logic             tick_s;
  logic             mod_active_s;
  logic [WIDTH-1:0] limit_s;
  logic             terminal_s;
  logic [WIDTH-1:0] load_s;

  // A finished one-shot freezes the prescaler as well as the count
  count_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en & running_q),
    .clr  (bus.ld),
    .div  (bus.presc_div),
    .tick (tick_s)
  );

  assign mod_active_s = (bus.mode == MOD) && (bus.modulus != ZERO);
  assign limit_s      = mod_active_s ? (bus.modulus - ONE) : ONES;
  // Up uses >= so an out-of-range count (after a modulus change) wraps next step
  assign terminal_s   = bus.dir ? (count_q >= limit_s) : (count_q == ZERO);
  assign load_s       = (mod_active_s && (bus.ld_val >= bus.modulus)) ? limit_s : bus.ld_val;

  // Next-state for count, terminal pulse and running flag
  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    running_d = running_q;
    if (bus.ld) begin
      count_d   = load_s;
      running_d = 1'b1;
    end else if (tick_s) begin
      if (!terminal_s) begin
        count_d = bus.dir ? (count_q + ONE) : (count_q - ONE);
      end else begin
        tc_d = 1'b1;
        case (bus.mode)
          WRAP, MOD: count_d   = bus.dir ? ZERO : limit_s;
          SAT:       count_d   = count_q;
          ONESHOT:   running_d = 1'b0;
          default:   count_d   = count_q;
        endcase
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= ZERO;
      tc_q      <= 1'b0;
      running_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = running_q;
  assign bus.zero    = (count_q == ZERO);

endmodule

// File: tb/tb_count_unit.sv
// Directed scenarios plus randomized traffic checked against a cycle model of count_unit.
module tb_count_unit;
  import count_pkg::*;

  localparam int W     = 8;
  localparam int PW    = 4;
  localparam int RANGE = 256;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int   m_cnt;
  int   m_p;
  bit   m_tc;
  bit   m_run;

  always #5 clk = ~clk;

  count_unit_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

  count_unit #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: range n is the number of count values, steps computed with plain integers
  task automatic model_update();
    bit tick;
    int n;
    if (rst) begin
      m_cnt = 0; m_p = 0; m_tc = 0; m_run = 1;
    end else if (bus.ld) begin
      m_cnt = int'(bus.ld_val);
      if (bus.mode == MOD && bus.modulus != 0 && bus.ld_val >= bus.modulus)
        m_cnt = int'(bus.modulus) - 1;
      m_p = 0; m_run = 1; m_tc = 0;
    end else begin
      tick = bus.en && m_run && (m_p >= int'(bus.presc_div));
      m_tc = 0;
      if (bus.en && m_run) m_p = tick ? 0 : m_p + 1;
      if (tick) begin
        n = (bus.mode == MOD && bus.modulus != 0) ? int'(bus.modulus) : RANGE;
        if (bus.dir ? (m_cnt >= n - 1) : (m_cnt == 0)) begin
          m_tc = 1;
          case (bus.mode)
            WRAP, MOD: m_cnt = bus.dir ? 0 : n - 1;
            ONESHOT:   m_run = 0;
            default:   m_cnt = m_cnt;
          endcase
        end else begin
          m_cnt = (m_cnt + (bus.dir ? 1 : RANGE - 1)) % RANGE;
        end
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_update();
    @(posedge clk);
    #1;
    chk({tag, ".count"},   32'(bus.count),   32'(m_cnt));
    chk({tag, ".tc"},      32'(bus.tc),      32'(m_tc));
    chk({tag, ".running"}, 32'(bus.running), 32'(m_run));
    chk({tag, ".zero"},    32'(bus.zero),    32'(m_cnt == 0));
  endtask

  initial begin
    int exp2 [5] = '{2, 1, 0, 9, 8};
    int exp3 [4] = '{254, 255, 255, 255};
    int tc3  [4] = '{0, 0, 1, 1};
    bit en5  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.en = 1'b0; bus.dir = 1'b1; bus.mode = WRAP; bus.modulus = 8'd0;
    bus.presc_div = 4'd0; bus.ld = 1'b0; bus.ld_val = 8'd0;
    cyc("reset");
    cyc("reset");
    chk("reset_zero", 32'(bus.zero), 32'd1);
    rst = 1'b0;

    // 1: free-running wrap
    bus.en = 1'b1;
    repeat (255) cyc("wrap");
    chk("wrap_top", 32'(bus.count), 32'd255);
    cyc("wrap");
    chk("wrap_zero", 32'(bus.count), 32'd0);
    chk("wrap_tc", 32'(bus.tc), 32'd1);
    cyc("wrap");
    chk("wrap_tc_clear", 32'(bus.tc), 32'd0);

    // 2: modulo-10 down count
    bus.mode = MOD; bus.modulus = 8'd10; bus.dir = 1'b0;
    bus.ld = 1'b1; bus.ld_val = 8'd3;
    cyc("mod_ld");
    bus.ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("mod");
      chk("mod_seq", 32'(bus.count), 32'(exp2[i]));
      chk("mod_tc", 32'(bus.tc), 32'(i == 3));
    end
    bus.ld = 1'b1; bus.ld_val = 8'd15;
    cyc("mod_ld_clip");
    chk("mod_ld_clip", 32'(bus.count), 32'd9);
    bus.ld = 1'b0;

    // 3: saturate up
    bus.mode = SAT; bus.dir = 1'b1; bus.ld = 1'b1; bus.ld_val = 8'd253;
    cyc("sat_ld");
    bus.ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("sat");
      chk("sat_seq", 32'(bus.count), 32'(exp3[i]));
      chk("sat_tc", 32'(bus.tc), 32'(tc3[i]));
    end
    bus.dir = 1'b0;
    cyc("sat_down");
    chk("sat_down", 32'(bus.count), 32'd254);

    // 4: one-shot down with prescaler 3
    bus.mode = ONESHOT; bus.presc_div = 4'd2; bus.ld = 1'b1; bus.ld_val = 8'd2;
    cyc("os_ld");
    bus.ld = 1'b0;
    repeat (3) cyc("os");
    chk("os_first", 32'(bus.count), 32'd1);
    repeat (3) cyc("os");
    chk("os_second", 32'(bus.count), 32'd0);
    chk("os_running_mid", 32'(bus.running), 32'd1);
    repeat (3) cyc("os");
    chk("os_tc", 32'(bus.tc), 32'd1);
    chk("os_done", 32'(bus.running), 32'd0);
    bus.mode = WRAP;
    repeat (6) cyc("os_idle");
    chk("os_hold", 32'(bus.count), 32'd0);
    chk("os_still_done", 32'(bus.running), 32'd0);
    bus.mode = ONESHOT; bus.ld = 1'b1; bus.ld_val = 8'd5;
    cyc("os_reload");
    chk("os_restart", 32'(bus.running), 32'd1);
    bus.ld = 1'b0;
    repeat (3) cyc("os_resume");
    chk("os_resume", 32'(bus.count), 32'd4);

    // 5: enable gating of the prescaler
    bus.mode = WRAP; bus.dir = 1'b1; bus.presc_div = 4'd1; bus.ld = 1'b1; bus.ld_val = 8'd0;
    cyc("en_ld");
    bus.ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.en = en5[i];
      cyc("en_gate");
      chk("en_gate", 32'(bus.count), 32'(i == 3));
    end
    bus.en = 1'b1;

    // 6: reset beats a simultaneous load
    bus.presc_div = 4'd3; bus.ld = 1'b1; bus.ld_val = 8'd77;
    cyc("rst_ld");
    bus.ld = 1'b0;
    cyc("rst_pre");
    chk("rst_pre", 32'(bus.count), 32'd77);
    rst = 1'b1; bus.ld = 1'b1; bus.ld_val = 8'd200;
    cyc("rst_mid");
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_tc", 32'(bus.tc), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd1);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    rst = 1'b0; bus.ld = 1'b0;

    // Randomized traffic with mid-run control changes
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom % 64) == 0;
      bus.ld        = ($urandom % 16) == 0;
      bus.en        = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) bus.dir = 1'($urandom % 2);
      if (($urandom % 8) == 0) bus.mode = mode_e'($urandom % 4);
      if (($urandom % 8) == 0)
        bus.modulus = ($urandom % 2) ? 8'($urandom_range(0, 20)) : 8'($urandom % 256);
      if (($urandom % 8) == 0) bus.presc_div = 4'($urandom_range(0, 2));
      bus.ld_val    = ($urandom % 2) ? 8'($urandom_range(0, 24)) : 8'($urandom % 256);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
